pe_seq_ctrl: RTL and testbench

//  Parametrised sequencer for the convolution PE array; replaces the fixed 28-wide, 8-channel-step controller.

---
 rtl/pe_seq_ctrl_pkg.sv | 23 ++
 rtl/pe_seq_ctrl_if.sv | 40 ++++
 rtl/pe_seq_ctrl_dly_line.sv | 26 ++
 rtl/pe_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_seq_ctrl_pkg.sv
// Shared types and default constants for the PE array sequencer (package pe_pkg).
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } pe_state_t;

  localparam int DEF_TILE_LEN  = 28;
  localparam int DEF_PRELOAD   = 4;
  localparam int DEF_CFG_W     = 2;
  localparam int DEF_CH_STEP   = 8;
  localparam int DEF_NUM_TILES = 32;
  localparam int DEF_OUT_DLY   = 4;

  // Bits needed to hold any value 0..max_val (at least one bit).
  function automatic int width_of(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Control/strobe bundle between the layer controller and the PE sequencer.
// The stall signal exists only when PE_SEQ_STALL_EN is defined.
interface pe_seq_ctrl_if
  import pe_pkg::*;
#(
  parameter int CFG_W = DEF_CFG_W
);

  logic             start_conv;
  logic             start_again;
  logic [CFG_W-1:0] cfg_ci;
  logic [CFG_W-1:0] cfg_co;
`ifdef PE_SEQ_STALL_EN
  logic             stall;
`endif
  logic             ifm_read;
  logic             wgt_read;
  logic             p_valid_out;
  logic             last_ch_out;
  logic             tile_done;
  logic             end_conv;
  logic             busy;

  modport master (
`ifdef PE_SEQ_STALL_EN
    output stall,
`endif
    output start_conv, start_again, cfg_ci, cfg_co,
    input  ifm_read, wgt_read, p_valid_out, last_ch_out, tile_done, end_conv, busy
  );

  modport slave (
`ifdef PE_SEQ_STALL_EN
    input  stall,
`endif
    input  start_conv, start_again, cfg_ci, cfg_co,
    output ifm_read, wgt_read, p_valid_out, last_ch_out, tile_done, end_conv, busy
  );

endinterface

// File: rtl/pe_seq_ctrl_dly_line.sv
// Fixed-depth shift register that aligns p_valid/last_ch with the PE pipeline.
module pe_dly_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift every cycle; reset flushes all stages so no stale valid escapes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_seq_ctrl.sv
// Parametrised PE array sequencer: walks channel passes, tiles and output groups.
// Optional PE_SEQ_STALL_EN adds a stall input that freezes the sequencer.
module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter int TILE_LEN  = DEF_TILE_LEN,
  parameter int PRELOAD   = DEF_PRELOAD,
  parameter int CFG_W     = DEF_CFG_W,
  parameter int CH_STEP   = DEF_CH_STEP,
  parameter int NUM_TILES = DEF_NUM_TILES,
  parameter int OUT_DLY   = DEF_OUT_DLY
) (
  input logic         clk,
  input logic         rst,
  pe_seq_ctrl_if.slave bus
);

  localparam int CI_W   = width_of((1 << CFG_W) * CH_STEP - 1);
  localparam int CO_W   = width_of(1 << CFG_W);
  localparam int TILE_W = width_of(NUM_TILES - 1);
  localparam int CYC_W  = width_of(((TILE_LEN > PRELOAD) ? TILE_LEN : PRELOAD) - 1);

  pe_state_t         state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CI_W-1:0]   ch_q, ch_d;
  logic [CI_W-1:0]   ci_max_q, ci_max_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [CO_W-1:0]   co_q, co_d;
  logic [CFG_W-1:0]  co_max_q, co_max_d;
  logic [CI_W-1:0]   ci_cfg;
  logic [CO_W-1:0]   co_end;
  logic              layer_done;
  logic              stall_w;
  logic              ifm_d, wgt_d, pv_d, last_d, tile_done_d, end_d;
  logic              ifm_q, wgt_q, pv_q, last_q, tile_done_q, end_q;
  logic [1:0]        dly_out;

`ifdef PE_SEQ_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  assign ci_cfg     = CI_W'((32'(bus.cfg_ci) + 32'd1) * 32'(CH_STEP) - 32'd1);
  assign co_end     = CO_W'(co_max_q) + CO_W'(1);
  assign layer_done = (tile_q == '0) && (co_q == co_end);

  // Next-state, counter updates and next values of the registered strobes.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    ch_d        = ch_q;
    ci_max_d    = ci_max_q;
    tile_d      = tile_q;
    co_d        = co_q;
    co_max_d    = co_max_q;
    tile_done_d = 1'b0;
    if (!stall_w) begin
      case (state_q)
        IDLE: begin
          if (bus.start_conv) begin
            ci_max_d = ci_cfg;
            co_max_d = bus.cfg_co;
            tile_d   = '0;
            co_d     = '0;
          end
          if (bus.start_again) begin
            cyc_d   = '0;
            state_d = (!bus.start_conv && layer_done) ? FINISH : LOAD;
          end
        end
        LOAD: begin
          if (cyc_q == CYC_W'(PRELOAD - 1)) begin
            cyc_d   = '0;
            state_d = STREAM;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        STREAM: begin
          if (cyc_q == CYC_W'(TILE_LEN - 1)) begin
            cyc_d = '0;
            if (ch_q < ci_max_q) begin
              ch_d    = ch_q + CI_W'(1);
              state_d = LOAD;
            end else begin
              ch_d        = '0;
              tile_done_d = 1'b1;
              state_d     = IDLE;
              if (tile_q == TILE_W'(NUM_TILES - 1)) begin
                tile_d = '0;
                co_d   = co_q + CO_W'(1);
              end else begin
                tile_d = tile_q + TILE_W'(1);
              end
            end
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        FINISH: begin
          ch_d    = '0;
          tile_d  = '0;
          co_d    = '0;
          cyc_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    ifm_d  = !stall_w && ((state_d == LOAD) || (state_d == STREAM));
    wgt_d  = !stall_w && (state_d == LOAD);
    pv_d   = !stall_w && (state_d == STREAM);
    last_d = !stall_w && (state_d == STREAM) && (ch_d == ci_max_d);
    end_d  = !stall_w && (state_d == FINISH);
  end

  // State, counters, latched config and strobes, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      ch_q        <= '0;
      ci_max_q    <= CI_W'(CH_STEP - 1);
      tile_q      <= '0;
      co_q        <= '0;
      co_max_q    <= '0;
      ifm_q       <= 1'b0;
      wgt_q       <= 1'b0;
      pv_q        <= 1'b0;
      last_q      <= 1'b0;
      tile_done_q <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      ch_q        <= ch_d;
      ci_max_q    <= ci_max_d;
      tile_q      <= tile_d;
      co_q        <= co_d;
      co_max_q    <= co_max_d;
      ifm_q       <= ifm_d;
      wgt_q       <= wgt_d;
      pv_q        <= pv_d;
      last_q      <= last_d;
      tile_done_q <= tile_done_d;
      end_q       <= end_d;
    end
  end

  pe_dly_line #(
    .WIDTH (2),
    .DEPTH (OUT_DLY)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({last_q, pv_q}),
    .dout (dly_out)
  );

  assign bus.ifm_read    = ifm_q;
  assign bus.wgt_read    = wgt_q;
  assign bus.p_valid_out = dly_out[0];
  assign bus.last_ch_out = dly_out[1];
  assign bus.tile_done   = tile_done_q;
  assign bus.end_conv    = end_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed testbench for pe_seq_ctrl with default parameters.
// Cycle numbers below count clock edges after the start_again edge.
module tb_pe_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pe_seq_ctrl_if #(.CFG_W(2)) bus ();

  pe_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc, n_ifm, n_wgt, n_pv, n_last, n_tile, n_end, n_win, n_gap;
  int first_pv, last_pv, first_last, tile_cyc, end_cyc;
  int win_lo, win_hi, gap_lo, gap_hi;

  task automatic clear_tally();
    cyc = 0; n_ifm = 0; n_wgt = 0; n_pv = 0; n_last = 0; n_tile = 0; n_end = 0;
    n_win = 0; n_gap = 0; first_pv = 0; last_pv = 0; first_last = 0;
    tile_cyc = 0; end_cyc = 0;
  endtask

  // Advance one clock and tally the outputs of the new cycle on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (bus.ifm_read) n_ifm++;
    if (bus.wgt_read) n_wgt++;
    if (bus.p_valid_out) begin
      n_pv++;
      if (first_pv == 0) first_pv = cyc;
      last_pv = cyc;
      if (cyc >= win_lo && cyc <= win_hi) n_win++;
      if (cyc >= gap_lo && cyc <= gap_hi) n_gap++;
    end
    if (bus.last_ch_out) begin
      n_last++;
      if (first_last == 0) first_last = cyc;
    end
    if (bus.tile_done) begin
      n_tile++;
      tile_cyc = cyc;
    end
    if (bus.end_conv) begin
      n_end++;
      end_cyc = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic latch_cfg(input logic [1:0] ci, input logic [1:0] co);
    bus.cfg_ci = ci;
    bus.cfg_co = co;
    bus.start_conv = 1'b1;
    step();
    bus.start_conv = 1'b0;
  endtask

  task automatic launch_tile();
    clear_tally();
    bus.start_again = 1'b1;
    step();
    bus.start_again = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run(3);
    checks++; if ({bus.ifm_read, bus.wgt_read} !== 2'b00) $display("[TB] FAIL reset_strobes: got %b want 00", {bus.ifm_read, bus.wgt_read}); else passed++;
    checks++; if ({bus.p_valid_out, bus.last_ch_out} !== 2'b00) $display("[TB] FAIL reset_delayed: got %b want 00", {bus.p_valid_out, bus.last_ch_out}); else passed++;
    checks++; if ({bus.tile_done, bus.end_conv, bus.busy} !== 3'b000) $display("[TB] FAIL reset_pulses_busy: got %b want 000", {bus.tile_done, bus.end_conv, bus.busy}); else passed++;
    rst = 1'b0;
    run(2);
  endtask

  task automatic test_single_tile();
    $display("[TB] single tile, cfg_ci=0 cfg_co=0");
    latch_cfg(2'd0, 2'd0);
    win_lo = 9; win_hi = 36; gap_lo = 0; gap_hi = -1;
    launch_tile();
    checks++; if ({bus.ifm_read, bus.wgt_read, bus.busy} !== 3'b111) $display("[TB] FAIL first_load_cycle: got %b want 111", {bus.ifm_read, bus.wgt_read, bus.busy}); else passed++;
    run(299);
    checks++; if (n_ifm !== 256) $display("[TB] FAIL ifm_count: got %0d want 256", n_ifm); else passed++;
    checks++; if (n_wgt !== 32) $display("[TB] FAIL wgt_count: got %0d want 32", n_wgt); else passed++;
    checks++; if (n_tile !== 1 || tile_cyc !== 257) $display("[TB] FAIL tile_done: got count %0d at %0d want 1 at 257", n_tile, tile_cyc); else passed++;
    checks++; if (n_pv !== 224) $display("[TB] FAIL pv_count: got %0d want 224", n_pv); else passed++;
    checks++; if (first_pv !== 9 || last_pv !== 260) $display("[TB] FAIL pv_span: got %0d..%0d want 9..260", first_pv, last_pv); else passed++;
    checks++; if (n_win !== 28) $display("[TB] FAIL pv_first_pass_contig: got %0d want 28", n_win); else passed++;
    checks++; if (n_last !== 28 || first_last !== 233) $display("[TB] FAIL last_ch: got %0d from %0d want 28 from 233", n_last, first_last); else passed++;
    checks++; if (n_end !== 0 || bus.busy !== 1'b0) $display("[TB] FAIL single_idle: got end %0d busy %b want 0 0", n_end, bus.busy); else passed++;
  endtask

  task automatic test_layer_end();
    int timeouts = 0;
    int prev;
    $display("[TB] full layer, cfg_co=1");
    latch_cfg(2'd0, 2'd1);
    win_lo = 0; win_hi = -1; gap_lo = 0; gap_hi = -1;
    clear_tally();
    for (int t = 0; t < 64; t++) begin
      prev = n_tile;
      bus.start_again = 1'b1;
      step();
      bus.start_again = 1'b0;
      for (int w = 0; w < 400 && n_tile == prev; w++) step();
      if (n_tile == prev) timeouts++;
    end
    checks++; if (timeouts !== 0 || n_tile !== 64) $display("[TB] FAIL layer_tiles: got %0d tiles %0d timeouts want 64 0", n_tile, timeouts); else passed++;
    checks++; if (n_end !== 0) $display("[TB] FAIL early_end_conv: got %0d want 0", n_end); else passed++;
    bus.start_again = 1'b1;
    step();
    bus.start_again = 1'b0;
    checks++; if ({bus.end_conv, bus.busy, bus.ifm_read} !== 3'b110) $display("[TB] FAIL finish_cycle: got %b want 110", {bus.end_conv, bus.busy, bus.ifm_read}); else passed++;
    step();
    checks++; if ({bus.end_conv, bus.busy} !== 2'b00) $display("[TB] FAIL after_finish: got %b want 00", {bus.end_conv, bus.busy}); else passed++;
    run(4);
    checks++; if (n_end !== 1) $display("[TB] FAIL end_conv_count: got %0d want 1", n_end); else passed++;
    launch_tile();
    checks++; if ({bus.wgt_read, bus.busy, bus.end_conv} !== 3'b110) $display("[TB] FAIL restart_after_finish: got %b want 110", {bus.wgt_read, bus.busy, bus.end_conv}); else passed++;
    run(300);
  endtask

  task automatic test_busy_ignore();
    $display("[TB] start pulses while busy");
    latch_cfg(2'd0, 2'd0);
    win_lo = 0; win_hi = -1; gap_lo = 0; gap_hi = -1;
    launch_tile();
    run(50);
    bus.cfg_ci = 2'd3;
    bus.cfg_co = 2'd3;
    bus.start_conv = 1'b1;
    bus.start_again = 1'b1;
    step();
    bus.start_conv = 1'b0;
    bus.start_again = 1'b0;
    run(300);
    checks++; if (n_ifm !== 256 || n_wgt !== 32) $display("[TB] FAIL busy_pass_counts: got ifm %0d wgt %0d want 256 32", n_ifm, n_wgt); else passed++;
    checks++; if (n_last !== 28 || first_last !== 233 || tile_cyc !== 257) $display("[TB] FAIL busy_timing: got last %0d@%0d tile@%0d want 28@233 tile@257", n_last, first_last, tile_cyc); else passed++;
    launch_tile();
    run(300);
    checks++; if (n_ifm !== 256 || n_tile !== 1 || n_end !== 0) $display("[TB] FAIL cfg_retained: got ifm %0d tiles %0d end %0d want 256 1 0", n_ifm, n_tile, n_end); else passed++;
    bus.cfg_ci = 2'd0;
    bus.cfg_co = 2'd0;
  endtask

  task automatic test_reset_mid();
    $display("[TB] reset during STREAM");
    latch_cfg(2'd0, 2'd0);
    win_lo = 0; win_hi = -1; gap_lo = 0; gap_hi = -1;
    launch_tile();
    run(19);
    checks++; if ({bus.ifm_read, bus.wgt_read} !== 2'b10) $display("[TB] FAIL pre_reset_stream: got %b want 10", {bus.ifm_read, bus.wgt_read}); else passed++;
    rst = 1'b1;
    step();
    checks++; if ({bus.ifm_read, bus.wgt_read, bus.p_valid_out, bus.last_ch_out, bus.tile_done, bus.end_conv, bus.busy} !== 7'b0)
      $display("[TB] FAIL mid_reset_outputs: got %b want 0000000", {bus.ifm_read, bus.wgt_read, bus.p_valid_out, bus.last_ch_out, bus.tile_done, bus.end_conv, bus.busy});
    else passed++;
    rst = 1'b0;
    clear_tally();
    run(8);
    checks++; if (n_pv !== 0 || n_end !== 0 || n_tile !== 0) $display("[TB] FAIL post_reset_quiet: got pv %0d end %0d tile %0d want 0 0 0", n_pv, n_end, n_tile); else passed++;
    bus.cfg_ci = 2'd0;
    bus.cfg_co = 2'd0;
    bus.start_conv = 1'b1;
    launch_tile();
    bus.start_conv = 1'b0;
    checks++; if ({bus.wgt_read, bus.busy} !== 2'b11) $display("[TB] FAIL same_cycle_start: got %b want 11", {bus.wgt_read, bus.busy}); else passed++;
    run(299);
    checks++; if (n_ifm !== 256 || first_last !== 233 || tile_cyc !== 257 || n_end !== 0) $display("[TB] FAIL restart_ch0: got ifm %0d last@%0d tile@%0d end %0d want 256 233 257 0", n_ifm, first_last, tile_cyc, n_end); else passed++;
  endtask

`ifdef PE_SEQ_STALL_EN
  task automatic test_stall();
    $display("[TB] stall 5 cycles mid-STREAM");
    latch_cfg(2'd0, 2'd0);
    win_lo = 9; win_hi = 41; gap_lo = 15; gap_hi = 19;
    launch_tile();
    run(9);
    bus.stall = 1'b1;
    run(5);
    bus.stall = 1'b0;
    run(290);
    checks++; if (n_ifm !== 256 || n_pv !== 224) $display("[TB] FAIL stall_counts: got ifm %0d pv %0d want 256 224", n_ifm, n_pv); else passed++;
    checks++; if (tile_cyc !== 262 || last_pv !== 265) $display("[TB] FAIL stall_timing: got tile@%0d pv_end@%0d want 262 265", tile_cyc, last_pv); else passed++;
    checks++; if (n_win !== 28 || n_gap !== 0) $display("[TB] FAIL stall_gap: got win %0d gap %0d want 28 0", n_win, n_gap); else passed++;
  endtask
`endif

  initial begin
    bus.start_conv = 1'b0;
    bus.start_again = 1'b0;
    bus.cfg_ci = 2'd0;
    bus.cfg_co = 2'd0;
`ifdef PE_SEQ_STALL_EN
    bus.stall = 1'b0;
`endif
    win_lo = 0; win_hi = -1; gap_lo = 0; gap_hi = -1;
    clear_tally();
    test_reset();
    test_single_tile();
    test_layer_end();
    test_busy_ignore();
    test_reset_mid();
`ifdef PE_SEQ_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
